mc_port_arbiter: RTL and testbench
==================================

Name: mc_port_arbiter

Overview:
- Shares the memory_controller's single read channel and single write channel between NUM_REQ requesters.
- Each requester has one read slot and one write slot, so it can have at most one read and one write outstanding.
- The controller returns completions tagged only by address. The block therefore tracks outstanding addresses, routes each return to its owner, and stalls address hazards.
- Sits between the requester agents and memory_controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 16, address width; matches controller rd/wr address
- DATA_W, 16, data width; matches controller rd/wr data
- CNT_W, $clog2(NUM_REQ+1), width of the outstanding counters

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_rd_valid  in  NUM_REQ  per-requester read request
- req_rd_addr  in  NUM_REQ*ADDR_W  read addresses, requester i at slice [i*ADDR_W +: ADDR_W]
- req_rd_ready  out  NUM_REQ  read accepted this cycle (combinational)
- req_wr_valid  in  NUM_REQ  per-requester write request
- req_wr_addr  in  NUM_REQ*ADDR_W  write addresses
- req_wr_data  in  NUM_REQ*DATA_W  write data
- req_wr_ready  out  NUM_REQ  write accepted this cycle (combinational)
- resp_rd_valid  out  NUM_REQ  one-cycle read completion pulse
- resp_rd_data  out  DATA_W  read data, valid with any resp_rd_valid bit
- resp_wr_valid  out  NUM_REQ  one-cycle write completion pulse
- mc_rd_en  out  1  to controller rd_en
- mc_rd_address  out  ADDR_W  to controller rd_address
- mc_rd_ret_ack  in  1  from controller rd_ret_ack
- mc_rd_ret_address  in  ADDR_W  from controller rd_ret_address
- mc_rd_ret_data  in  DATA_W  from controller rd_ret_data
- mc_wr_en  out  1  to controller wr_en
- mc_wr_address  out  ADDR_W  to controller wr_address
- mc_wr_data  out  DATA_W  to controller wr_data
- mc_wr_ret_ack  in  1  from controller wr_ret_ack
- mc_wr_ret_address  in  ADDR_W  from controller wr_ret_address
- rd_outstanding  out  CNT_W  number of valid read-table entries
- wr_outstanding  out  CNT_W  number of valid write-table entries
- err_unmatched  out  1  one-cycle pulse: a return matched no table entry

Behaviour:
- Reset: every output register is 0, all table entries invalid, both round-robin pointers 0. Reset asserted mid-operation discards all in-flight tracking.
- Tables: rd_tab[i] and wr_tab[i] each hold {valid, addr}, one entry per requester.
- Read eligibility for requester i, all of:
  - req_rd_valid[i];
  - !rd_tab[i].valid;
  - addr matches no valid wr_tab entry (RAW hazard);
  - addr matches no valid rd_tab entry (keeps return routing unambiguous).
- Write eligibility is symmetric:
  - req_wr_valid[i];
  - !wr_tab[i].valid;
  - addr matches no valid rd_tab entry and no valid wr_tab entry.
- Arbitration:
  - Independent round-robin per channel; the winner is the first eligible index at or after ptr.
  - At most one read grant and one write grant per cycle; req_*_ready is one-hot or zero.
  - On a grant, ptr <= winner+1 mod NUM_REQ; otherwise ptr holds.
- Issue: a grant in cycle N registers mc_*_en=1 with address/data in cycle N+1, and sets the table entry at the N edge. With no grant, mc_*_en=0 and address/data hold their last value.
- Same-cycle read and write to one address from different requesters: the read channel has priority; the write sees the new rd_tab entry next cycle and stalls.
- Return on mc_rd_ret_ack in cycle M:
  - Compare the return address with valid rd_tab entries; by construction at most one matches.
  - On a match, that entry clears at the M edge.
  - resp_rd_valid[i] pulses in M+1, with resp_rd_data = registered mc_rd_ret_data.
  - Write returns behave the same, driving resp_wr_valid.
- No match on a return: err_unmatched=1 in M+1, no table change, no response pulse.
- Slot release and regrant: eligibility uses pre-edge table state. A requester whose entry clears in cycle M can be granted again no earlier than M+1 (no bypass).
- Hazard comparisons also use pre-edge state, so a same-cycle return does not unblock a hazard in cycle M.
- Counters: rd_outstanding/wr_outstanding are registered popcounts of the table valid bits and never exceed NUM_REQ.
- Address wrap needs no special handling; comparisons are exact ADDR_W equality.

Decomposition:
- Package mc_arb_pkg:
  - ADDR_W and DATA_W defaults;
  - typedef entry_t {logic valid; logic [ADDR_W-1:0] addr};
  - function popcount.
- Sub-module rr_arbiter #(N) (req[N], ptr) -> (gnt one-hot, gnt_idx, any), purely combinational; instantiated once per channel.

Test Plan:
- Single read: req 0 requests rd addr 0x0010 in cycle 5 -> ready[0]=1 in cycle 5, mc_rd_en=1 with address 0x0010 in cycle 6, rd_outstanding=1. Ret_ack with address 0x0010 and data 0xBEEF in cycle 20 -> resp_rd_valid=0001 and data 0xBEEF in cycle 21, rd_outstanding=0.
- Round robin: all 4 requesters hold rd_valid with distinct addresses and returns come 3 cycles after issue -> grants in order 0,1,2,3,0,...; no requester is granted twice before every other requester is granted once.
- RAW hazard: req 1 writes 0x0040 (outstanding), then req 2 reads 0x0040 -> req_rd_ready[2]=0 until the write return at cycle M; grant no earlier than M+1.
- Out-of-order returns: reads to 0x0001 (req 0) and 0x0002 (req 3) outstanding; return 0x0002 arrives first -> resp_rd_valid=1000, then 0001.
- Unmatched return: rd_ret_ack with address 0x7777 and no entries valid -> err_unmatched pulses one cycle, rd_outstanding unchanged, no resp pulse.
- Reset mid-flight: 2 reads outstanding, assert rst_n=0 asynchronously -> outputs 0 immediately, counters 0. After release, a late return for one of those reads -> err_unmatched pulse.

Source files
------------

// File: rtl/mc_arb_pkg.sv
// Shared types and helpers for the memory-controller port arbiter.
// Table entries pair a valid bit with the tracked address.
package mc_arb_pkg;

    localparam int unsigned DefaultAddrW = 16;
    localparam int unsigned DefaultDataW = 16;
    localparam int unsigned MaxReq       = 8;

    typedef struct packed {
        logic                    valid;
        logic [DefaultAddrW-1:0] addr;
    } entry_t;

    function automatic logic [3:0] popcount(input logic [MaxReq-1:0] bits);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxReq; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr_i.
// Outputs are zero when nothing requests.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    int unsigned idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares the controller's read and write channels among NUM_REQ requesters, tracking
// outstanding addresses so address-only returns route back to their owner.
module mc_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = DefaultAddrW,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned CNT_W   = $clog2(NUM_REQ + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_rd_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
    output logic [NUM_REQ-1:0]        req_rd_ready,
    input  logic [NUM_REQ-1:0]        req_wr_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]        req_wr_ready,
    output logic [NUM_REQ-1:0]        resp_rd_valid,
    output logic [DATA_W-1:0]         resp_rd_data,
    output logic [NUM_REQ-1:0]        resp_wr_valid,
    output logic                      mc_rd_en,
    output logic [ADDR_W-1:0]         mc_rd_address,
    input  logic                      mc_rd_ret_ack,
    input  logic [ADDR_W-1:0]         mc_rd_ret_address,
    input  logic [DATA_W-1:0]         mc_rd_ret_data,
    output logic                      mc_wr_en,
    output logic [ADDR_W-1:0]         mc_wr_address,
    output logic [DATA_W-1:0]         mc_wr_data,
    input  logic                      mc_wr_ret_ack,
    input  logic [ADDR_W-1:0]         mc_wr_ret_address,
    output logic [CNT_W-1:0]          rd_outstanding,
    output logic [CNT_W-1:0]          wr_outstanding,
    output logic                      err_unmatched
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    entry_t rd_tab_q [NUM_REQ];
    entry_t rd_tab_d [NUM_REQ];
    entry_t wr_tab_q [NUM_REQ];
    entry_t wr_tab_d [NUM_REQ];

    logic [NUM_REQ-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt, rd_hit, wr_hit, rd_vld_d, wr_vld_d;
    logic [IdxW-1:0]    rd_idx, wr_idx, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic               rd_any, wr_any;
    logic [ADDR_W-1:0]  rd_gnt_addr, wr_gnt_addr;
    logic [DATA_W-1:0]  wr_gnt_data;

    logic                mc_rd_en_q, mc_rd_en_d, mc_wr_en_q, mc_wr_en_d;
    logic [ADDR_W-1:0]   mc_rd_address_q, mc_rd_address_d, mc_wr_address_q, mc_wr_address_d;
    logic [DATA_W-1:0]   mc_wr_data_q, mc_wr_data_d, resp_rd_data_q, resp_rd_data_d;
    logic [NUM_REQ-1:0]  resp_rd_valid_q, resp_rd_valid_d, resp_wr_valid_q, resp_wr_valid_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                err_q, err_d;

    // Hazard check against pre-edge table state only: a same-cycle return never unblocks.
    function automatic logic addr_busy(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            hit |= (rd_tab_q[j].valid && rd_tab_q[j].addr == a) ||
                   (wr_tab_q[j].valid && wr_tab_q[j].addr == a);
        end
        return hit;
    endfunction

    always_comb begin
        rd_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_elig[i] = req_rd_valid[i] && !rd_tab_q[i].valid &&
                         !addr_busy(req_rd_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    rr_arbiter #(.N(NUM_REQ), .IdxW(IdxW)) u_rd_arb (
        .req_i     (rd_elig),
        .ptr_i     (rd_ptr_q),
        .gnt_o     (rd_gnt),
        .gnt_idx_o (rd_idx),
        .any_o     (rd_any)
    );

    assign rd_gnt_addr = req_rd_addr[rd_idx*ADDR_W +: ADDR_W];

    // A same-cycle read grant to the same address wins over any write.
    always_comb begin
        wr_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_elig[i] = req_wr_valid[i] && !wr_tab_q[i].valid &&
                         !addr_busy(req_wr_addr[i*ADDR_W +: ADDR_W]) &&
                         !(rd_any && rd_gnt_addr == req_wr_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    rr_arbiter #(.N(NUM_REQ), .IdxW(IdxW)) u_wr_arb (
        .req_i     (wr_elig),
        .ptr_i     (wr_ptr_q),
        .gnt_o     (wr_gnt),
        .gnt_idx_o (wr_idx),
        .any_o     (wr_any)
    );

    assign wr_gnt_addr  = req_wr_addr[wr_idx*ADDR_W +: ADDR_W];
    assign wr_gnt_data  = req_wr_data[wr_idx*DATA_W +: DATA_W];
    assign req_rd_ready = rd_gnt;
    assign req_wr_ready = wr_gnt;

    always_comb begin
        rd_tab_d = rd_tab_q;
        wr_tab_d = wr_tab_q;
        rd_hit   = '0;
        wr_hit   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rd_hit[j] = mc_rd_ret_ack && rd_tab_q[j].valid &&
                        rd_tab_q[j].addr == mc_rd_ret_address;
            wr_hit[j] = mc_wr_ret_ack && wr_tab_q[j].valid &&
                        wr_tab_q[j].addr == mc_wr_ret_address;
            if (rd_hit[j]) rd_tab_d[j].valid = 1'b0;
            if (wr_hit[j]) wr_tab_d[j].valid = 1'b0;
        end
        if (rd_any) rd_tab_d[rd_idx] = '{valid: 1'b1, addr: rd_gnt_addr};
        if (wr_any) wr_tab_d[wr_idx] = '{valid: 1'b1, addr: wr_gnt_addr};
        for (int j = 0; j < NUM_REQ; j++) begin
            rd_vld_d[j] = rd_tab_d[j].valid;
            wr_vld_d[j] = wr_tab_d[j].valid;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_any) rd_ptr_d = (rd_idx == IdxW'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
        if (wr_any) wr_ptr_d = (wr_idx == IdxW'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1;

        mc_rd_en_d      = rd_any;
        mc_rd_address_d = rd_any ? rd_gnt_addr : mc_rd_address_q;
        mc_wr_en_d      = wr_any;
        mc_wr_address_d = wr_any ? wr_gnt_addr : mc_wr_address_q;
        mc_wr_data_d    = wr_any ? wr_gnt_data : mc_wr_data_q;
        resp_rd_valid_d = rd_hit;
        resp_rd_data_d  = (|rd_hit) ? mc_rd_ret_data : resp_rd_data_q;
        resp_wr_valid_d = wr_hit;
        err_d           = (mc_rd_ret_ack && !(|rd_hit)) || (mc_wr_ret_ack && !(|wr_hit));
        rd_cnt_d        = CNT_W'(popcount(MaxReq'(rd_vld_d)));
        wr_cnt_d        = CNT_W'(popcount(MaxReq'(wr_vld_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                rd_tab_q[j] <= '0;
                wr_tab_q[j] <= '0;
            end
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            mc_rd_en_q      <= 1'b0;
            mc_rd_address_q <= '0;
            mc_wr_en_q      <= 1'b0;
            mc_wr_address_q <= '0;
            mc_wr_data_q    <= '0;
            resp_rd_valid_q <= '0;
            resp_rd_data_q  <= '0;
            resp_wr_valid_q <= '0;
            err_q           <= 1'b0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
        end else begin
            rd_tab_q        <= rd_tab_d;
            wr_tab_q        <= wr_tab_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            mc_rd_en_q      <= mc_rd_en_d;
            mc_rd_address_q <= mc_rd_address_d;
            mc_wr_en_q      <= mc_wr_en_d;
            mc_wr_address_q <= mc_wr_address_d;
            mc_wr_data_q    <= mc_wr_data_d;
            resp_rd_valid_q <= resp_rd_valid_d;
            resp_rd_data_q  <= resp_rd_data_d;
            resp_wr_valid_q <= resp_wr_valid_d;
            err_q           <= err_d;
            rd_cnt_q        <= rd_cnt_d;
            wr_cnt_q        <= wr_cnt_d;
        end
    end

    assign mc_rd_en       = mc_rd_en_q;
    assign mc_rd_address  = mc_rd_address_q;
    assign mc_wr_en       = mc_wr_en_q;
    assign mc_wr_address  = mc_wr_address_q;
    assign mc_wr_data     = mc_wr_data_q;
    assign resp_rd_valid  = resp_rd_valid_q;
    assign resp_rd_data   = resp_rd_data_q;
    assign resp_wr_valid  = resp_wr_valid_q;
    assign err_unmatched  = err_q;
    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed and randomized checks of mc_port_arbiter against a per-requester slot model
// in which the bench itself plays the memory controller.
module tb_mc_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_rd_valid, req_rd_ready, req_wr_valid, req_wr_ready;
    logic [NR*AW-1:0] req_rd_addr, req_wr_addr;
    logic [NR*DW-1:0] req_wr_data;
    logic [NR-1:0]   resp_rd_valid, resp_wr_valid;
    logic [DW-1:0]   resp_rd_data;
    logic            mc_rd_en, mc_wr_en, mc_rd_ret_ack, mc_wr_ret_ack, err_unmatched;
    logic [AW-1:0]   mc_rd_address, mc_wr_address, mc_rd_ret_address, mc_wr_ret_address;
    logic [DW-1:0]   mc_rd_ret_data, mc_wr_data;
    logic [CW-1:0]   rd_outstanding, wr_outstanding;

    always #5 clk = ~clk;

    mc_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_rd_valid      (req_rd_valid),
        .req_rd_addr       (req_rd_addr),
        .req_rd_ready      (req_rd_ready),
        .req_wr_valid      (req_wr_valid),
        .req_wr_addr       (req_wr_addr),
        .req_wr_data       (req_wr_data),
        .req_wr_ready      (req_wr_ready),
        .resp_rd_valid     (resp_rd_valid),
        .resp_rd_data      (resp_rd_data),
        .resp_wr_valid     (resp_wr_valid),
        .mc_rd_en          (mc_rd_en),
        .mc_rd_address     (mc_rd_address),
        .mc_rd_ret_ack     (mc_rd_ret_ack),
        .mc_rd_ret_address (mc_rd_ret_address),
        .mc_rd_ret_data    (mc_rd_ret_data),
        .mc_wr_en          (mc_wr_en),
        .mc_wr_address     (mc_wr_address),
        .mc_wr_data        (mc_wr_data),
        .mc_wr_ret_ack     (mc_wr_ret_ack),
        .mc_wr_ret_address (mc_wr_ret_address),
        .rd_outstanding    (rd_outstanding),
        .wr_outstanding    (wr_outstanding),
        .err_unmatched     (err_unmatched)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which requesters own an outstanding read/write slot, and for which address.
    bit            m_rd_v [NR];
    bit            m_wr_v [NR];
    logic [AW-1:0] m_rd_a [NR];
    logic [AW-1:0] m_wr_a [NR];
    int            m_rd_ptr, m_wr_ptr;
    logic          e_rd_en, e_wr_en, e_err;
    logic [AW-1:0] e_rd_addr, e_wr_addr;
    logic [DW-1:0] e_wr_data, e_rd_data;
    logic [NR-1:0] e_rresp, e_wresp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rd_a(input int i);
        return req_rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wr_a(input int i);
        return req_wr_addr[i*AW +: AW];
    endfunction

    function automatic bit busy(input logic [AW-1:0] a);
        for (int j = 0; j < NR; j++) begin
            if ((m_rd_v[j] && m_rd_a[j] == a) || (m_wr_v[j] && m_wr_a[j] == a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int count(input bit v [NR]);
        int c = 0;
        for (int j = 0; j < NR; j++) c += int'(v[j]);
        return c;
    endfunction

    task automatic reset_model();
        for (int j = 0; j < NR; j++) begin
            m_rd_v[j] = 0; m_wr_v[j] = 0; m_rd_a[j] = '0; m_wr_a[j] = '0;
        end
        m_rd_ptr = 0; m_wr_ptr = 0;
        e_rd_en = 0; e_wr_en = 0; e_err = 0;
        e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_rd_data = '0;
        e_rresp = '0; e_wresp = '0;
    endtask

    task automatic set_idle();
        req_rd_valid = '0; req_wr_valid = '0;
        mc_rd_ret_ack = 1'b0; mc_wr_ret_ack = 1'b0;
    endtask

    // One clock: predict grants and returns from current inputs, check ready, then outputs.
    task automatic cycle();
        int rw, ww, rm, wm, i;
        logic [NR-1:0] er, ew;
        rw = -1; ww = -1; rm = -1; wm = -1;
        for (int k = 0; k < NR; k++) begin
            i = (m_rd_ptr + k) % NR;
            if (rw < 0 && req_rd_valid[i] && !m_rd_v[i] && !busy(rd_a(i))) rw = i;
        end
        for (int k = 0; k < NR; k++) begin
            i = (m_wr_ptr + k) % NR;
            if (ww < 0 && req_wr_valid[i] && !m_wr_v[i] && !busy(wr_a(i)) &&
                !(rw >= 0 && rd_a(rw) == wr_a(i))) ww = i;
        end
        for (int j = 0; j < NR; j++) begin
            if (mc_rd_ret_ack && m_rd_v[j] && m_rd_a[j] == mc_rd_ret_address) rm = j;
            if (mc_wr_ret_ack && m_wr_v[j] && m_wr_a[j] == mc_wr_ret_address) wm = j;
        end
        er = (rw >= 0) ? (NR'(1) << rw) : '0;
        ew = (ww >= 0) ? (NR'(1) << ww) : '0;
        e_err   = (mc_rd_ret_ack && rm < 0) || (mc_wr_ret_ack && wm < 0);
        e_rresp = (rm >= 0) ? (NR'(1) << rm) : '0;
        e_wresp = (wm >= 0) ? (NR'(1) << wm) : '0;
        if (rm >= 0) begin m_rd_v[rm] = 0; e_rd_data = mc_rd_ret_data; end
        if (wm >= 0) m_wr_v[wm] = 0;
        e_rd_en = (rw >= 0);
        e_wr_en = (ww >= 0);
        if (rw >= 0) begin
            m_rd_v[rw] = 1; m_rd_a[rw] = rd_a(rw); m_rd_ptr = (rw + 1) % NR;
            e_rd_addr = rd_a(rw);
        end
        if (ww >= 0) begin
            m_wr_v[ww] = 1; m_wr_a[ww] = wr_a(ww); m_wr_ptr = (ww + 1) % NR;
            e_wr_addr = wr_a(ww); e_wr_data = req_wr_data[ww*DW +: DW];
        end
        #1;
        chk("rd_ready", 32'(req_rd_ready), 32'(er));
        chk("wr_ready", 32'(req_wr_ready), 32'(ew));
        @(posedge clk);
        #1;
        chk("mc_rd_en", 32'(mc_rd_en), 32'(e_rd_en));
        chk("mc_rd_address", 32'(mc_rd_address), 32'(e_rd_addr));
        chk("mc_wr_en", 32'(mc_wr_en), 32'(e_wr_en));
        chk("mc_wr_address", 32'(mc_wr_address), 32'(e_wr_addr));
        chk("mc_wr_data", 32'(mc_wr_data), 32'(e_wr_data));
        chk("resp_rd_valid", 32'(resp_rd_valid), 32'(e_rresp));
        chk("resp_rd_data", 32'(resp_rd_data), 32'(e_rd_data));
        chk("resp_wr_valid", 32'(resp_wr_valid), 32'(e_wresp));
        chk("err_unmatched", 32'(err_unmatched), 32'(e_err));
        chk("rd_outstanding", 32'(rd_outstanding), 32'(count(m_rd_v)));
        chk("wr_outstanding", 32'(wr_outstanding), 32'(count(m_wr_v)));
    endtask

    initial begin
        int pick;
        req_rd_addr = '0; req_wr_addr = '0; req_wr_data = '0;
        mc_rd_ret_address = '0; mc_wr_ret_address = '0; mc_rd_ret_data = '0;
        set_idle();
        reset_model();
        rst_n = 1'b0;
        #12;
        chk("reset_mc_rd_en", 32'(mc_rd_en), 0);
        chk("reset_rd_outstanding", 32'(rd_outstanding), 0);
        chk("reset_wr_outstanding", 32'(wr_outstanding), 0);
        chk("reset_err", 32'(err_unmatched), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round robin: all requesters always asking, each read returned 3 cycles after grant.
        for (int i = 0; i < NR; i++) req_rd_addr[i*AW +: AW] = 16'h0200 + 16'(i);
        for (int t = 0; t < 15; t++) begin
            req_rd_valid  = (t < 12) ? '1 : '0;
            mc_rd_ret_ack = (t >= 3);
            mc_rd_ret_address = 16'h0200 + 16'((t - 3) % NR);
            mc_rd_ret_data = 16'h1000 + 16'(t);
            #1;
            chk("rr_order", 32'(req_rd_ready), (t < 12) ? (32'd1 << (t % NR)) : 0);
            cycle();
        end
        set_idle();

        // Single read with a late return.
        req_rd_valid = 4'b0001;
        req_rd_addr[0 +: AW] = 16'h0010;
        #1;
        chk("single_ready", 32'(req_rd_ready), 32'h1);
        cycle();
        chk("single_issue_addr", 32'(mc_rd_address), 32'h0010);
        chk("single_outstanding", 32'(rd_outstanding), 1);
        set_idle();
        repeat (3) cycle();
        mc_rd_ret_ack = 1'b1; mc_rd_ret_address = 16'h0010; mc_rd_ret_data = 16'hBEEF;
        cycle();
        chk("single_resp", 32'(resp_rd_valid), 32'h1);
        chk("single_data", 32'(resp_rd_data), 32'hBEEF);
        chk("single_drained", 32'(rd_outstanding), 0);
        set_idle();

        // Out-of-order returns route by address.
        req_rd_addr[0 +: AW] = 16'h0001;
        req_rd_addr[3*AW +: AW] = 16'h0002;
        req_rd_valid = 4'b1001;
        repeat (2) cycle();
        set_idle();
        cycle();
        mc_rd_ret_ack = 1'b1; mc_rd_ret_address = 16'h0002; mc_rd_ret_data = 16'h2222;
        cycle();
        chk("ooo_first", 32'(resp_rd_valid), 32'h8);
        mc_rd_ret_address = 16'h0001; mc_rd_ret_data = 16'h1111;
        cycle();
        chk("ooo_second", 32'(resp_rd_valid), 32'h1);
        set_idle();

        // RAW hazard: read of a pending write address waits for the write return, plus a cycle.
        req_wr_valid = 4'b0010;
        req_wr_addr[1*AW +: AW] = 16'h0040;
        req_wr_data[1*DW +: DW] = 16'hCAFE;
        cycle();
        set_idle();
        req_rd_valid = 4'b0100;
        req_rd_addr[2*AW +: AW] = 16'h0040;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("raw_stall", 32'(req_rd_ready), 0);
            cycle();
        end
        mc_wr_ret_ack = 1'b1; mc_wr_ret_address = 16'h0040;
        #1;
        chk("raw_stall_on_return", 32'(req_rd_ready), 0);
        cycle();
        mc_wr_ret_ack = 1'b0;
        #1;
        chk("raw_grant_after", 32'(req_rd_ready), 32'h4);
        cycle();
        set_idle();
        mc_rd_ret_ack = 1'b1; mc_rd_ret_address = 16'h0040; mc_rd_ret_data = 16'h4040;
        cycle();
        set_idle();

        // Unmatched return.
        mc_rd_ret_ack = 1'b1; mc_rd_ret_address = 16'h7777; mc_rd_ret_data = 16'h5555;
        cycle();
        chk("unmatched_err", 32'(err_unmatched), 1);
        chk("unmatched_noresp", 32'(resp_rd_valid), 0);
        set_idle();
        cycle();
        chk("unmatched_pulse_ends", 32'(err_unmatched), 0);

        // Reset mid-flight with two reads outstanding, then a late return for one of them.
        req_rd_addr[0 +: AW] = 16'h0100;
        req_rd_addr[1*AW +: AW] = 16'h0101;
        req_rd_valid = 4'b0011;
        repeat (2) cycle();
        set_idle();
        rst_n = 1'b0;
        #2;
        chk("midrst_mc_rd_en", 32'(mc_rd_en), 0);
        chk("midrst_addr", 32'(mc_rd_address), 0);
        chk("midrst_outstanding", 32'(rd_outstanding), 0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mc_rd_ret_ack = 1'b1; mc_rd_ret_address = 16'h0100; mc_rd_ret_data = 16'h0BAD;
        cycle();
        chk("late_return_err", 32'(err_unmatched), 1);
        set_idle();

        // Randomized traffic over a small address pool to provoke hazards and returns.
        for (int t = 0; t < 400; t++) begin
            req_rd_valid = NR'($urandom);
            req_wr_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_rd_addr[i*AW +: AW] = 16'h0040 + 16'($urandom_range(0, 5));
                req_wr_addr[i*AW +: AW] = 16'h0040 + 16'($urandom_range(0, 5));
                req_wr_data[i*DW +: DW] = 16'($urandom);
            end
            mc_rd_ret_ack = ($urandom_range(0, 2) == 0);
            mc_rd_ret_address = 16'h7000 + 16'($urandom_range(0, 15));
            mc_rd_ret_data = 16'($urandom);
            pick = $urandom_range(0, NR - 1);
            if (m_rd_v[pick] && $urandom_range(0, 7) != 0) mc_rd_ret_address = m_rd_a[pick];
            mc_wr_ret_ack = ($urandom_range(0, 2) == 0);
            mc_wr_ret_address = 16'h7000 + 16'($urandom_range(0, 15));
            pick = $urandom_range(0, NR - 1);
            if (m_wr_v[pick] && $urandom_range(0, 7) != 0) mc_wr_ret_address = m_wr_a[pick];
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
